// File: rtl/lcv_alu_rr_arbiter_if.sv
// Handshake bundle between requesters, the shared 1-cycle ALU and the response consumer.
interface lcv_alu_rr_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int OP_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_b_0;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_b_1;
  logic [NUM_REQ-1:0]                req_b_sel;
  logic [NUM_REQ-1:0][OP_WIDTH-1:0]  req_op;

  logic [WIDTH-1:0]                  alu_inp_a;
  logic [WIDTH-1:0]                  alu_inp_b_0;
  logic [WIDTH-1:0]                  alu_inp_b_1;
  logic                              alu_inp_b_sel;
  logic [OP_WIDTH-1:0]               alu_inp_op;
  logic [WIDTH-1:0]                  alu_outp_data;

  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [ID_W-1:0]                   rsp_id;
  logic [WIDTH-1:0]                  rsp_data;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b_0, req_b_1, req_b_sel, req_op, alu_outp_data, rsp_ready,
    output req_ready, alu_inp_a, alu_inp_b_0, alu_inp_b_1, alu_inp_b_sel, alu_inp_op,
           rsp_valid, rsp_id, rsp_data
  );

  // Requester / ALU / consumer side
  modport master (
    output req_valid, req_a, req_b_0, req_b_1, req_b_sel, req_op, alu_outp_data, rsp_ready,
    input  req_ready, alu_inp_a, alu_inp_b_0, alu_inp_b_1, alu_inp_b_sel, alu_inp_op,
           rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/lcv_alu_rr_arbiter.sv
// Round-robin share of one 1-cycle registered ALU among NUM_REQ requesters.
// Results are tagged with the requester id and queued in a 2-entry FIFO;
// issue is gated so that FIFO occupancy plus the in-flight op never exceeds 2.
module lcv_alu_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int OP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  lcv_alu_rr_arbiter_if.slave bus
);
  localparam int            ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]  r_ptr;
  logic             r_inflight;
  logic [ID_W-1:0]  r_inflight_id;
  logic [1:0]       r_occ;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [ID_W-1:0]  r_fifo_id   [2];
  logic [WIDTH-1:0] r_fifo_data [2];

  logic             w_rsp_valid;
  logic             w_pop;
  logic [2:0]       w_load;
  logic             w_can_issue;
  logic [ID_W:0]    w_idx;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W-1:0]  w_ptr_nxt;

  // Outputs are forced quiet while reset is asserted, whatever the state holds.
  assign w_rsp_valid = rst && (r_occ != 2'd0);
  assign w_pop       = w_rsp_valid && bus.rsp_ready;
  // Slots committed after this cycle: queued + in flight - leaving now.
  assign w_load      = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_can_issue = w_load < 3'd2;
  assign w_ptr_nxt   = (w_gnt_id == LAST) ? '0 : w_gnt_id + ID_W'(1);

  // First valid requester scanning ptr, ptr+1, ... with wrap at NUM_REQ.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_gnt_vld && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx[ID_W-1:0];
      end
    end
    w_gnt_vld = w_gnt_vld && w_can_issue && rst;
  end

  // Grant decode and operand steering to the shared ALU.
  always_comb begin
    bus.req_ready = '0;
    if (w_gnt_vld) bus.req_ready[w_gnt_id] = 1'b1;
    bus.alu_inp_a     = bus.req_a[w_gnt_id];
    bus.alu_inp_b_0   = bus.req_b_0[w_gnt_id];
    bus.alu_inp_b_1   = bus.req_b_1[w_gnt_id];
    bus.alu_inp_b_sel = bus.req_b_sel[w_gnt_id];
    bus.alu_inp_op    = w_gnt_vld ? bus.req_op[w_gnt_id] : '0;
  end

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_fifo_id[r_rd_ptr];
  assign bus.rsp_data  = r_fifo_data[r_rd_ptr];

  // Pointer, in-flight tracking and FIFO; an op in flight during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr         <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_occ         <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
    end else begin
      r_inflight <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_inflight_id <= w_gnt_id;
        r_ptr         <= w_ptr_nxt;
      end
      if (r_inflight) begin
        r_fifo_id[r_wr_ptr]   <= r_inflight_id;
        r_fifo_data[r_wr_ptr] <= bus.alu_outp_data;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // The credit check must make a push into a full FIFO unreachable.
  always_ff @(posedge clk) begin
    if (rst) assert (!(r_inflight && r_occ == 2'd2));
  end
endmodule
